// File: rtl/fm_bram_writer_if.sv
// Bus bundle for the feature-map writer: pixel stream in, tile start/status,
// and the dual-port BRAM write side toward conv_2's feature-map memory.
interface fm_bram_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              fm_bram_wea;
  logic              fm_bram_web;
  logic [ADDR_W-1:0] fm_bram_addra;
  logic [ADDR_W-1:0] fm_bram_addrb;
  logic [DATA_W-1:0] fm_bram_dina;
  logic [DATA_W-1:0] fm_bram_dinb;
  logic              busy;
  logic              fm_write_finish;

  modport master (
    output start, pix_valid, pix_data,
    input  pix_ready, fm_bram_wea, fm_bram_web, fm_bram_addra, fm_bram_addrb,
           fm_bram_dina, fm_bram_dinb, busy, fm_write_finish
  );

  modport slave (
    input  start, pix_valid, pix_data,
    output pix_ready, fm_bram_wea, fm_bram_web, fm_bram_addra, fm_bram_addrb,
           fm_bram_dina, fm_bram_dinb, busy, fm_write_finish
  );
endinterface

// File: rtl/fm_bram_writer.sv
// Writes one tile of pooled pixels into the feature-map BRAM, two pixels per
// cycle through ports A (even index) and B (odd index), then pulses finish.
module fm_bram_writer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int NUM_WORDS = 32
) (
  input logic             clk,
  input logic             rst,
  fm_bram_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EVEN, ODD, FLUSH, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pix_ready_q, pix_ready_d;
  logic              wea_q, wea_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic [DATA_W-1:0] dinb_q, dinb_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;
  logic              xfer;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    wea_d    = 1'b0;
    web_d    = 1'b0;
    addra_d  = addra_q;
    addrb_d  = addrb_q;
    dina_d   = dina_q;
    dinb_d   = dinb_q;
    finish_d = 1'b0;
    xfer     = bus.pix_valid && pix_ready_q;
    idx      = cnt_q[ADDR_W-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = EVEN;
          cnt_d   = '0;
        end
      end
      EVEN: begin
        if (xfer) begin
          hold_d = bus.pix_data;
          cnt_d  = cnt_q + 1'b1;
          // An odd-sized tile ends on an even pixel with no partner for port B.
          if (cnt_q == LAST_IDX) begin
            state_d = FLUSH;
            wea_d   = 1'b1;
            addra_d = idx;
            dina_d  = bus.pix_data;
          end else begin
            state_d = ODD;
          end
        end
      end
      ODD: begin
        if (xfer) begin
          wea_d   = 1'b1;
          web_d   = 1'b1;
          addra_d = idx - 1'b1;
          addrb_d = idx;
          dina_d  = hold_q;
          dinb_d  = bus.pix_data;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_IDX) ? FLUSH : EVEN;
        end
      end
      FLUSH: begin
        state_d  = DONE;
        finish_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pix_ready_d = (state_d == EVEN) || (state_d == ODD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      pix_ready_q <= 1'b0;
      wea_q       <= 1'b0;
      web_q       <= 1'b0;
      addra_q     <= '0;
      addrb_q     <= '0;
      dina_q      <= '0;
      dinb_q      <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      pix_ready_q <= pix_ready_d;
      wea_q       <= wea_d;
      web_q       <= web_d;
      addra_q     <= addra_d;
      addrb_q     <= addrb_d;
      dina_q      <= dina_d;
      dinb_q      <= dinb_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

  assign bus.pix_ready       = pix_ready_q;
  assign bus.fm_bram_wea     = wea_q;
  assign bus.fm_bram_web     = web_q;
  assign bus.fm_bram_addra   = addra_q;
  assign bus.fm_bram_addrb   = addrb_q;
  assign bus.fm_bram_dina    = dina_q;
  assign bus.fm_bram_dinb    = dinb_q;
  assign bus.busy            = busy_q;
  assign bus.fm_write_finish = finish_q;

endmodule

// File: tb/tb_fm_bram_writer.sv
// Bench for fm_bram_writer: a cycle table on a 5-word instance and tile
// sequences on a 32-word instance observed through a BRAM model.
module tb_fm_bram_writer;

  typedef struct packed {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        ready;
    logic        busy;
    logic        finish;
    logic        wea;
    logic        web;
    logic [2:0]  addra;
    logic [2:0]  addrb;
    logic [15:0] dina;
    logic [15:0] dinb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fm_bram_writer_if #(.DATA_W(16), .ADDR_W(5)) bus32();
  fm_bram_writer_if #(.DATA_W(16), .ADDR_W(3)) bus5();

  fm_bram_writer #(.DATA_W(16), .ADDR_W(5), .NUM_WORDS(32)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  fm_bram_writer #(.DATA_W(16), .ADDR_W(3), .NUM_WORDS(5)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5)
  );

  // BRAM model and write statistics for the 32-word instance.
  logic [15:0] mem32 [32];
  logic        ready_prev = 1'b0;
  logic        acc_now;
  int          cyc = 0;
  int          last_acc = -10;
  int          pairs = 0;
  int          singles = 0;
  int          web_only = 0;
  int          fins = 0;
  int          strobe_viol = 0;
  int          fin_lat_viol = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    acc_now = bus32.pix_valid && ready_prev;
    if (acc_now) last_acc = cyc;
    if ((bus32.fm_bram_wea || bus32.fm_bram_web) && !acc_now) strobe_viol = strobe_viol + 1;
    if (bus32.fm_bram_wea) mem32[bus32.fm_bram_addra] = bus32.fm_bram_dina;
    if (bus32.fm_bram_web) mem32[bus32.fm_bram_addrb] = bus32.fm_bram_dinb;
    if (bus32.fm_bram_wea && bus32.fm_bram_web) pairs = pairs + 1;
    else if (bus32.fm_bram_wea) singles = singles + 1;
    else if (bus32.fm_bram_web) web_only = web_only + 1;
    if (bus32.fm_write_finish) begin
      fins = fins + 1;
      if (cyc != last_acc + 1) fin_lat_viol = fin_lat_viol + 1;
    end
    ready_prev = bus32.pix_ready;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic [15:0] d,
                              input logic r, input logic b, input logic f,
                              input logic wa, input logic wb,
                              input logic [2:0] aa, input logic [2:0] ab,
                              input logic [15:0] da, input logic [15:0] db);
    vec_t t;
    t.start = s;  t.valid = v;  t.data = d;
    t.ready = r;  t.busy = b;   t.finish = f;
    t.wea = wa;   t.web = wb;   t.addra = aa; t.addrb = ab;
    t.dina = da;  t.dinb = db;
    return t;
  endfunction

  task automatic apply_stimulus(input logic [15:0] d, input int gap);
    int waited;
    bus32.pix_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      #1;
    end
    bus32.pix_valid = 1'b1;
    bus32.pix_data  = d;
    waited = 0;
    while (!bus32.pix_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) check_output("ready_timeout", 64'(bus32.pix_ready), 64'(1));
    @(negedge clk);
    #1;
    bus32.pix_valid = 1'b0;
  endtask

  task automatic start_tile32();
    bus32.start = 1'b1;
    @(negedge clk);
    #1;
    bus32.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  vec_t        vecs [18];
  logic [15:0] bub [32];
  int          p0, s0, f0;
  logic [15:0] m6;

  initial begin
    bus32.start = 1'b0; bus32.pix_valid = 1'b0; bus32.pix_data = 16'd0;
    bus5.start  = 1'b0; bus5.pix_valid  = 1'b0; bus5.pix_data  = 16'd0;

    //          s     v     data     rdy   busy  fin   wea   web   aa    ab    dina     dinb
    vecs[0]  = mk(1'b1, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0,  16'd0);
    vecs[1]  = mk(1'b0, 1'b1, 16'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0,  16'd0);
    vecs[2]  = mk(1'b0, 1'b1, 16'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 16'd10, 16'd11);
    vecs[3]  = mk(1'b0, 1'b0, 16'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'd10, 16'd11);
    vecs[4]  = mk(1'b0, 1'b1, 16'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'd10, 16'd11);
    vecs[5]  = mk(1'b0, 1'b1, 16'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 3'd3, 16'd12, 16'd13);
    vecs[6]  = mk(1'b0, 1'b1, 16'd14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 3'd3, 16'd14, 16'd13);
    vecs[7]  = mk(1'b0, 1'b1, 16'd99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd3, 16'd14, 16'd13);
    vecs[8]  = mk(1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 16'd14, 16'd13);
    vecs[9]  = mk(1'b0, 1'b1, 16'd55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 16'd14, 16'd13);
    vecs[10] = mk(1'b1, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 16'd14, 16'd13);
    vecs[11] = mk(1'b1, 1'b1, 16'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 16'd14, 16'd13);
    vecs[12] = mk(1'b1, 1'b1, 16'd21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 16'd20, 16'd21);
    vecs[13] = mk(1'b0, 1'b1, 16'd22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'd20, 16'd21);
    vecs[14] = mk(1'b0, 1'b1, 16'd23, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 3'd3, 16'd22, 16'd23);
    vecs[15] = mk(1'b0, 1'b1, 16'd24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 3'd3, 16'd24, 16'd23);
    vecs[16] = mk(1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd3, 16'd24, 16'd23);
    vecs[17] = mk(1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 16'd24, 16'd23);

    #2 rst = 1'b0;
    #1;
    check_output("reset_outputs_32", 64'({bus32.pix_ready, bus32.busy, bus32.fm_write_finish,
                 bus32.fm_bram_wea, bus32.fm_bram_web, bus32.fm_bram_addra, bus32.fm_bram_addrb,
                 bus32.fm_bram_dina, bus32.fm_bram_dinb}), 64'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Cycle table on the 5-word tile: odd flush, bubble, start in DONE/busy, valid in IDLE.
    for (int k = 0; k < 18; k++) begin
      bus5.start     = vecs[k].start;
      bus5.pix_valid = vecs[k].valid;
      bus5.pix_data  = vecs[k].data;
      @(negedge clk);
      check_output($sformatf("vec%0d", k),
                   64'({bus5.pix_ready, bus5.busy, bus5.fm_write_finish, bus5.fm_bram_wea,
                        bus5.fm_bram_web, bus5.fm_bram_addra, bus5.fm_bram_addrb,
                        bus5.fm_bram_dina, bus5.fm_bram_dinb}),
                   64'({vecs[k].ready, vecs[k].busy, vecs[k].finish, vecs[k].wea,
                        vecs[k].web, vecs[k].addra, vecs[k].addrb,
                        vecs[k].dina, vecs[k].dinb}));
      #1;
    end
    bus5.start = 1'b0;
    bus5.pix_valid = 1'b0;

    // Full 32-pixel tile, back-to-back.
    p0 = pairs; s0 = singles; f0 = fins;
    start_tile32();
    for (int i = 0; i < 32; i++) apply_stimulus(16'(32'h100 + i), 0);
    idle_cycles(4);
    check_output("full_pairs", 64'(pairs - p0), 64'(16));
    check_output("full_singles", 64'(singles - s0), 64'(0));
    check_output("full_finish_count", 64'(fins - f0), 64'(1));
    for (int i = 0; i < 32; i++)
      check_output($sformatf("full_mem%0d", i), 64'(mem32[i]), 64'(32'h100 + i));

    // Bubbly tile with random gaps of 0..3 idle cycles.
    for (int i = 0; i < 32; i++) bub[i] = 16'($urandom);
    p0 = pairs; f0 = fins;
    start_tile32();
    for (int i = 0; i < 32; i++) apply_stimulus(bub[i], int'($urandom_range(3, 0)));
    idle_cycles(4);
    check_output("bubbly_pairs", 64'(pairs - p0), 64'(16));
    check_output("bubbly_finish_count", 64'(fins - f0), 64'(1));
    for (int i = 0; i < 32; i++)
      check_output($sformatf("bubbly_mem%0d", i), 64'(mem32[i]), 64'(bub[i]));

    // Reset after 7 pixels: three pairs land, pixel 6 never does, no finish.
    m6 = mem32[6];
    p0 = pairs; s0 = singles; f0 = fins;
    start_tile32();
    for (int i = 0; i < 7; i++) apply_stimulus(16'(32'h200 + i), 0);
    rst = 1'b0;
    #1;
    check_output("midreset_outputs_32", 64'({bus32.pix_ready, bus32.busy, bus32.fm_write_finish,
                 bus32.fm_bram_wea, bus32.fm_bram_web, bus32.fm_bram_addra, bus32.fm_bram_addrb,
                 bus32.fm_bram_dina, bus32.fm_bram_dinb}), 64'(0));
    check_output("midreset_outputs_5", 64'({bus5.pix_ready, bus5.busy, bus5.fm_write_finish,
                 bus5.fm_bram_wea, bus5.fm_bram_web, bus5.fm_bram_addra, bus5.fm_bram_addrb,
                 bus5.fm_bram_dina, bus5.fm_bram_dinb}), 64'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(3);
    check_output("midreset_idle", 64'({bus32.pix_ready, bus32.busy}), 64'(0));
    check_output("midreset_pairs", 64'(pairs - p0), 64'(3));
    check_output("midreset_singles", 64'(singles - s0), 64'(0));
    check_output("midreset_no_finish", 64'(fins - f0), 64'(0));
    check_output("midreset_pix6_unwritten", 64'(mem32[6]), 64'(m6));
    for (int i = 0; i < 6; i++)
      check_output($sformatf("midreset_mem%0d", i), 64'(mem32[i]), 64'(32'h200 + i));

    // Clean tile after the abandoned one starts again from address 0.
    p0 = pairs; f0 = fins;
    start_tile32();
    for (int i = 0; i < 32; i++) apply_stimulus(16'(32'h300 + i), 0);
    idle_cycles(4);
    check_output("clean_pairs", 64'(pairs - p0), 64'(16));
    check_output("clean_finish_count", 64'(fins - f0), 64'(1));
    for (int i = 0; i < 32; i++)
      check_output($sformatf("clean_mem%0d", i), 64'(mem32[i]), 64'(32'h300 + i));

    check_output("strobe_outside_accept", 64'(strobe_viol), 64'(0));
    check_output("port_b_without_a", 64'(web_only), 64'(0));
    check_output("finish_latency", 64'(fin_lat_viol), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fm_bram_writer.md
Name: fm_bram_writer

Overview:
- Write side of the dual-port feature-map BRAM that conv_2 reads through its port A and port B interfaces.
- Accepts a stream of pooled pixels from the previous pooling stage and writes one tile of NUM_WORDS pixels into the BRAM.
- Writes pixel pairs through both ports in the same cycle, then pulses a finish flag that downstream control uses to start conv_2.

Parameters:
- DATA_W, 16, pixel/BRAM word width in bits
- ADDR_W, 5, BRAM address width; must satisfy NUM_WORDS <= 2^ADDR_W
- NUM_WORDS, 32, pixels per tile; odd values are legal

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a tile; honoured only in IDLE
- pix_valid  input  1  upstream pixel valid
- pix_data  input  DATA_W  upstream pixel value
- pix_ready  output  1  block can accept a pixel; transfer occurs when pix_valid and pix_ready are both 1 on a rising edge
- fm_bram_wea  output  1  port A write enable (registered)
- fm_bram_web  output  1  port B write enable (registered)
- fm_bram_addra  output  ADDR_W  port A address (even pixel index)
- fm_bram_addrb  output  ADDR_W  port B address (odd pixel index)
- fm_bram_dina  output  DATA_W  port A write data
- fm_bram_dinb  output  DATA_W  port B write data
- busy  output  1  high from the start acceptance until the cycle after the finish pulse
- fm_write_finish  output  1  one-cycle pulse when the whole tile is in the BRAM

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0: wea, web, addra, addrb, dina, dinb, pix_ready, busy, fm_write_finish.
  - Pixel counter (ADDR_W+1 bits) and even-pixel holding register are cleared.
- Reset during a tile: the partial tile is abandoned. No finish pulse is generated. Addresses already written keep their BRAM contents.
- FSM states: IDLE, EVEN, ODD, FLUSH, DONE.
- IDLE:
  - pix_ready=0.
  - start=1 sends the FSM to EVEN, clears the counter and sets busy=1.
- EVEN (waiting for an even-index pixel):
  - pix_ready=1.
  - On a transfer: latch pix_data into the holding register and increment the counter.
  - If that pixel is index NUM_WORDS-1 (odd NUM_WORDS), go to FLUSH and register a single port A write: wea=1, web=0, addra=index, dina=pixel. Otherwise go to ODD.
- ODD:
  - pix_ready=1.
  - On a transfer, register a paired write for the next cycle:
    - wea=web=1
    - addra=index-1, dina=holding register
    - addrb=index, dinb=pix_data
  - Increment the counter. Go to FLUSH if index = NUM_WORDS-1, else go to EVEN.
- Write strobe latency: exactly 1 cycle after the accepting edge. Strobes are high for exactly one cycle per write. Addresses and data hold their last value when strobes are low.
- FLUSH:
  - pix_ready=0; strobes show the final write.
  - Next edge: go to DONE.
- DONE:
  - fm_write_finish=1 for this cycle only; strobes are 0.
  - Next edge: go to IDLE and drop busy.
- Finish-pulse latency: finish occurs 2 cycles after the edge that accepts the last pixel.
- pix_valid with pix_ready=0 is ignored. The upstream stage must hold pix_data until the transfer.
- start outside IDLE is ignored; no restart and no counter clear.
- start in the same cycle as DONE is ignored, because the FSM is not yet in IDLE.
- Address wrap-around cannot occur: the counter stops at NUM_WORDS, and addresses never exceed NUM_WORDS-1.
- Idle cycles between transfers (pix_valid=0) stall the FSM. No writes are issued and the holding register is kept.

Test Plan:
- Reset check: pulse rst=0 mid-sim -> every output is 0 immediately (asynchronous), and the FSM is in IDLE.
- Full tile, NUM_WORDS=32, pix_valid held high, data 0x0100+i after start:
  - 16 paired writes: (A addr 0 = 0x0100, B addr 1 = 0x0101) ... (A addr 30 = 0x011E, B addr 31 = 0x011F), each one cycle after its odd accept.
  - fm_write_finish pulses once, 2 cycles after the pixel-31 accept.
- Odd tile, NUM_WORDS=5, data 10..14:
  - Writes are (0=10, 1=11), (2=12, 3=13), then A-only addr 4 = 14 with web=0.
  - One finish pulse.
- Bubbly input: random pix_valid gaps of 0–3 cycles on a 32-pixel tile -> the BRAM model matches the input order and no strobe fires in a gap cycle.
- Protocol edges:
  - start repeated while busy -> no effect on addresses.
  - start during DONE -> ignored, and a new tile begins only from a start issued in IDLE.
  - pix_valid in IDLE -> no write.
- Reset mid-tile after 7 pixels:
  - The first 3 pairs are written; pixel 6 is never written; no finish pulse.
  - A following start writes a clean tile from addr 0.
